video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Free-running raster timing generator for the MENU core. It produces the
//  pixel/line counters, blanking, sync, and a per-frame scroll accumulator.
//  These feed the backdrop pattern logic, osd, and scandoubler directly
//  downstream. Defaults give a 15 kHz, 312-line PAL-like raster.
// PARAMETERS
//  H_TOTAL      640  pixels per line; hc counts 0..H_TOTAL-1
//  HBLANK_START 310  hc value that sets hblank
//  HBLANK_END   440  hc value that clears hblank
//  HSYNC_START  336  hc value that sets hsync
//  HSYNC_END    368  hc value that clears hsync
//  V_TOTAL      312  lines per frame; vc counts 0..V_TOTAL-1
//  VBLANK_START 306  vc value that sets vblank
//  VBLANK_END   2    vc value that clears vblank
//  VSYNC_START  308  vc value that sets vsync
//  VSYNC_END    0    vc value that clears vsync
//  FRAME_STEP   6    added to scroll each frame
// PORTS
//  clk_pix      in   1   pixel clock; the only clock
//  reset        in   1   synchronous, active-high reset
//  ce_pix       in   1   pixel enable; all state advances only when 1
//  hc           out  10  horizontal pixel counter
//  vc           out  9   vertical line counter
//  scroll       out  10  frame accumulator, modulo 1024
//  hblank       out  1   horizontal blank, active high
//  vblank       out  1   vertical blank, active high
//  hsync        out  1   horizontal sync, active high
//  vsync        out  1   vertical sync, active high
//  de           out  1   display enable = !hblank && !vblank (registered)
//  line_start   out  1   1-cycle pulse when hc wraps to 0
//  frame_start  out  1   1-cycle pulse when hc and vc both wrap to 0
//  rnd          out  23  LFSR noise word (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: hc=0, vc=0, scroll=0, and every flag and pulse = 0.
//    rnd resets to 23'h000001.
//  - When ce_pix=0, all registers hold and the pulses are 0. Pulses last
//    exactly one ce_pix cycle.
//  - hc: if hc==H_TOTAL-1, hc<=0; otherwise hc<=hc+1.
//  - vc advances only on the hc wrap. If vc==V_TOTAL-1, vc<=0 and
//    scroll<=scroll+FRAME_STEP; otherwise vc<=vc+1. Arithmetic is 10-bit
//    unsigned and scroll wraps 1023 -> (1023+FRAME_STEP)&1023.
//  - Flags are set/clear registers evaluated on the current hc/vc. They
//    change one ce_pix cycle after the matching count, e.g. hblank rises
//    on the edge where hc becomes 311.
//  - If a START value equals the END value, set takes priority.
//  - vblank, vsync and de are updated on every ce_pix, not only at line
//    wrap.
//  - de is registered from the next-state hblank/vblank, so it aligns
//    with the flags.
//  - line_start is asserted in the cycle where hc==0 is presented.
//    frame_start additionally requires vc==0.
//  - Reset asserted mid-frame returns everything to the reset values on
//    the next clk_pix edge, regardless of ce_pix. Counting restarts from
//    hc=0, vc=0 with no spurious pulse.
//  - Parameters are static. Out-of-range START/END values leave the
//    flag at its reset value permanently; this is legal, not an error.
// CONFIGURATION
//  VTG_NOISE_EN defined: rnd is a 23-bit Fibonacci LFSR, taps 23 and 18
//    (x^23+x^18+1). It shifts once per ce_pix and never reaches 0.
//  VTG_NOISE_EN undefined: rnd is constant 0 and no LFSR logic is built.
// TESTING
//  1 Reset, then 640 ce_pix -> hc runs 0..639 then 0; vc 0->1;
//    line_start high only at the wrap.
//  2 Free-run 199680 ce_pix -> one frame_start; scroll 0->6; vsync high
//    for 4 lines (vc 308..311).
//  3 ce_pix toggled 1/0 -> counters advance every other clock; line
//    period is 1280 clocks; pulses are 1 clock wide.
//  4 Run 171 frames -> scroll = (171*6)&1023 = 2 (wrap checked).
//  5 Assert reset at hc=500, vc=200 -> next edge all outputs at reset
//    values; release -> hc=1 after one ce_pix.
//  6 With VTG_NOISE_EN: 2^23-1 shifts -> rnd returns to 23'h000001 and
//    is never 0. Without it: rnd==0 throughout.

Source files
------------

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: pixel/line counters, blank/sync flags,
// line/frame pulses and a per-frame scroll accumulator. Optional macro VTG_NOISE_EN adds a 23-bit LFSR on rnd.
module video_timing_gen #(
    parameter int unsigned H_TOTAL      = 640,
    parameter int unsigned HBLANK_START = 310,
    parameter int unsigned HBLANK_END   = 440,
    parameter int unsigned HSYNC_START  = 336,
    parameter int unsigned HSYNC_END    = 368,
    parameter int unsigned V_TOTAL      = 312,
    parameter int unsigned VBLANK_START = 306,
    parameter int unsigned VBLANK_END   = 2,
    parameter int unsigned VSYNC_START  = 308,
    parameter int unsigned VSYNC_END    = 0,
    parameter int unsigned FRAME_STEP   = 6
) (
    input  logic        clk_pix,
    input  logic        reset,
    input  logic        ce_pix,
    output logic [9:0]  hc,
    output logic [8:0]  vc,
    output logic [9:0]  scroll,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line_start,
    output logic        frame_start,
    output logic [22:0] rnd
);

    localparam logic [9:0] STEP = 10'(FRAME_STEP);

    logic [9:0] hc_q, hc_d;
    logic [8:0] vc_q, vc_d;
    logic [9:0] scroll_q, scroll_d;
    logic       hblank_q, hblank_d;
    logic       vblank_q, vblank_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic       line_start_q, frame_start_q;
    logic       h_wrap, v_wrap;

    // Set wins over clear so equal START/END values latch the flag high.
    function automatic logic flag_next(input logic q, input logic set, input logic clr);
        logic r;
        r = q;
        if (set) begin
            r = 1'b1;
        end else if (clr) begin
            r = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        h_wrap   = (32'(hc_q) == H_TOTAL - 1);
        v_wrap   = (32'(vc_q) == V_TOTAL - 1);
        hc_d     = h_wrap ? 10'd0 : hc_q + 10'd1;
        vc_d     = vc_q;
        scroll_d = scroll_q;
        if (h_wrap) begin
            if (v_wrap) begin
                vc_d     = 9'd0;
                scroll_d = scroll_q + STEP;
            end else begin
                vc_d = vc_q + 9'd1;
            end
        end
        hblank_d = flag_next(hblank_q, 32'(hc_q) == HBLANK_START, 32'(hc_q) == HBLANK_END);
        hsync_d  = flag_next(hsync_q,  32'(hc_q) == HSYNC_START,  32'(hc_q) == HSYNC_END);
        vblank_d = flag_next(vblank_q, 32'(vc_q) == VBLANK_START, 32'(vc_q) == VBLANK_END);
        vsync_d  = flag_next(vsync_q,  32'(vc_q) == VSYNC_START,  32'(vc_q) == VSYNC_END);
        de_d     = !hblank_d && !vblank_d;
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            scroll_q      <= '0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (ce_pix) begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            scroll_q      <= scroll_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

`ifdef VTG_NOISE_EN
    logic [22:0] rnd_q, rnd_d;

    // Fibonacci LFSR x^23 + x^18 + 1; seeded non-zero so it never locks up.
    assign rnd_d = {rnd_q[21:0], rnd_q[22] ^ rnd_q[17]};

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            rnd_q <= 23'h000001;
        end else if (ce_pix) begin
            rnd_q <= rnd_d;
        end
    end

    assign rnd = rnd_q;
`else
    assign rnd = '0;
`endif

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign scroll      = scroll_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a scaled raster: an arithmetic model derived from
// the count of pixel enables since reset is compared with the DUT on every clock.
module tb_video_timing_gen;

    localparam longint HT  = 40;
    localparam longint HBS = 30;
    localparam longint HBE = 38;
    localparam longint HSS = 32;
    localparam longint HSE = 35;
    localparam longint VT  = 12;
    localparam longint VBS = 9;
    localparam longint VBE = 2;
    localparam longint VSS = 10;
    localparam longint STP = 100;
    localparam longint FRM = HT * VT;

    logic        clk_pix = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic [9:0]  hc;
    logic [8:0]  vc;
    logic [9:0]  scroll;
    logic        hblank, vblank, hsync, vsync, de, line_start, frame_start;
    logic [22:0] rnd;

    int     checks = 0;
    int     errors = 0;
    bit     checking = 0;
    longint n = 0;
    bit     pulse_ok = 0;
    logic [22:0] lfsr_m = 23'h000001;

    video_timing_gen #(
        .H_TOTAL(40), .HBLANK_START(30), .HBLANK_END(38),
        .HSYNC_START(32), .HSYNC_END(35),
        .V_TOTAL(12), .VBLANK_START(9), .VBLANK_END(2),
        .VSYNC_START(10), .VSYNC_END(0), .FRAME_STEP(100)
    ) dut (
        .clk_pix(clk_pix), .reset(reset), .ce_pix(ce_pix),
        .hc(hc), .vc(vc), .scroll(scroll),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .de(de), .line_start(line_start), .frame_start(frame_start),
        .rnd(rnd)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at n=%0d t=%0t", name, act, exp, n, $time);
        end
    endtask

    // Model state: number of pixel enables since reset, and whether the last edge was one.
    always @(posedge clk_pix) begin
        if (reset) begin
            n        <= 0;
            pulse_ok <= 1'b0;
            lfsr_m   <= 23'h000001;
        end else if (ce_pix) begin
            n        <= n + 1;
            pulse_ok <= 1'b1;
            lfsr_m   <= {lfsr_m[21:0], lfsr_m[22] ^ lfsr_m[17]};
        end else begin
            pulse_ok <= 1'b0;
        end
    end

    always @(negedge clk_pix) begin
        longint hc_e, vc_e, sc_e, p, hp, vp, fp;
        bit started, hb_e, vb_e, hs_e, vs_e;
        if (checking) begin
            hc_e    = n % HT;
            vc_e    = (n / HT) % VT;
            sc_e    = ((n / FRM) * STP) % 1024;
            started = (n >= 1);
            p       = started ? n - 1 : 0;
            hp      = p % HT;
            vp      = (p / HT) % VT;
            fp      = p / FRM;
            hb_e    = started && hp >= HBS && hp < HBE;
            hs_e    = started && hp >= HSS && hp < HSE;
            vb_e    = started && (vp >= VBS || (vp < VBE && fp >= 1));
            vs_e    = started && vp >= VSS;
            check("hc", hc, hc_e);
            check("vc", vc, vc_e);
            check("scroll", scroll, sc_e);
            check("hblank", hblank, hb_e);
            check("hsync", hsync, hs_e);
            check("vblank", vblank, vb_e);
            check("vsync", vsync, vs_e);
            check("de", de, started && !hb_e && !vb_e);
            check("line_start", line_start, pulse_ok && hc_e == 0);
            check("frame_start", frame_start, pulse_ok && hc_e == 0 && vc_e == 0);
`ifdef VTG_NOISE_EN
            check("rnd", rnd, lfsr_m);
            check("rnd_nonzero", rnd == 0, 0);
`else
            check("rnd", rnd, 0);
`endif
        end
    end

    // mode 0: ce always 1, mode 1: alternate 1/0, mode 2: random.
    task automatic run_to(input longint target, input int mode);
        int guard = 0;
        bit t = 1'b1;
        while (n < target && guard < 40000) begin
            case (mode)
                0:       ce_pix = 1'b1;
                1:       ce_pix = t;
                default: ce_pix = 1'($urandom_range(0, 1));
            endcase
            t = ~t;
            @(negedge clk_pix);
            guard++;
        end
        ce_pix = 1'b0;
        if (n < target) check("run_timeout", n, target);
    endtask

    initial begin
        reset  = 1'b1;
        ce_pix = 1'b1;
        repeat (3) @(negedge clk_pix);
        checking = 1;
        check("rst_hc", hc, 0);
        check("rst_vc", vc, 0);
        check("rst_scroll", scroll, 0);
        check("rst_de", de, 0);
        check("rst_line_start", line_start, 0);
`ifdef VTG_NOISE_EN
        check("rst_rnd", rnd, 23'h000001);
`else
        check("rst_rnd", rnd, 0);
`endif
        reset = 1'b0;

        run_to(40, 0);
        check("lit_line_hc", hc, 0);
        check("lit_line_vc", vc, 1);
        check("lit_line_pulse", line_start, 1);

        run_to(FRM, 0);
        check("lit_frame_pulse", frame_start, 1);
        check("lit_frame_vc", vc, 0);
        check("lit_frame_scroll", scroll, 100);

        run_to(FRM + 2 * HT, 1);
        check("lit_toggle_vc", vc, 2);

        run_to(11 * FRM, 2);
        check("lit_scroll_wrap", scroll, 76);

        run_to(11 * FRM + 5 * HT + 20, 2);
        check("lit_mid_hc", hc, 20);
        reset  = 1'b1;
        ce_pix = 1'($urandom_range(0, 1));
        @(negedge clk_pix);
        check("mid_rst_hc", hc, 0);
        check("mid_rst_vc", vc, 0);
        check("mid_rst_scroll", scroll, 0);
        check("mid_rst_flags", {hblank, vblank, hsync, vsync, de}, 0);
        check("mid_rst_pulses", {line_start, frame_start}, 0);
        reset  = 1'b0;
        ce_pix = 1'b1;
        @(negedge clk_pix);
        ce_pix = 1'b0;
        check("post_rst_hc", hc, 1);
        check("post_rst_pulse", line_start, 0);

        for (int i = 0; i < 4000; i++) begin
            reset  = ($urandom_range(0, 499) == 0);
            ce_pix = 1'($urandom_range(0, 3) != 0);
            @(negedge clk_pix);
        end
        reset  = 1'b0;
        ce_pix = 1'b0;
        @(negedge clk_pix);
        checking = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
